// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and the grey-pattern select codes
// shared by the raster generator and its sub-blocks.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int MAX_TOTAL = 2048;
    localparam int POS_W     = 11;

    typedef enum logic [1:0] {
        PAT_PASS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

endpackage

// File: rtl/vga_sync_counter.sv
// One raster axis: position counter with wrap, plus registered sync and
// active flags that always describe the position currently held in pos.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE   = DEF_H_ACTIVE,
    parameter int   FP       = DEF_H_FP,
    parameter int   SYNC     = DEF_H_SYNC,
    parameter int   BP       = DEF_H_BP,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [POS_W-1:0] pos,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [POS_W-1:0] LAST    = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] SYNC_LO = POS_W'(ACTIVE + FP);
    localparam logic [POS_W-1:0] SYNC_HI = POS_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [POS_W-1:0] ACT_END = POS_W'(ACTIVE);

    logic [POS_W-1:0] nxt;

    // Reset parks on the last position so the first enable enters 0.
    assign wrap = (pos == LAST);
    assign nxt  = wrap ? '0 : pos + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pos    <= LAST;
            sync   <= ~SYNC_ACT;
            active <= 1'b0;
        end else if (en) begin
            pos    <= nxt;
            sync   <= (nxt >= SYNC_LO && nxt <= SYNC_HI) ? SYNC_ACT : ~SYNC_ACT;
            active <= (nxt < ACT_END);
        end
    end

endmodule

// File: rtl/vga_raster_gen.sv
// Raster timing generator with grey pattern source: two axis counters, the
// frame-latched pattern select, a divider-free bar counter and the grey mux.
module vga_raster_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [1:0]       pattern_sel,
    input  logic [7:0]       grey_in,
    output logic [POS_W-1:0] vga_x,
    output logic [POS_W-1:0] vga_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       grey_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam logic [POS_W-1:0] HA       = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] VA       = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] BAR_LAST = POS_W'(BAR_W - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $error("vga_raster_gen: H_TOTAL/V_TOTAL exceed 2048");
    end

    logic             h_active, v_active, h_wrap, v_wrap, v_en;
    logic [POS_W-1:0] x_nxt, y_nxt, bar_cnt, bar_cnt_nxt;
    logic [2:0]       bar_k, bar_k_nxt;
    logic             enter_frame, de_nxt;
    pattern_e         mode, mode_nxt;
    logic [7:0]       grey_nxt;

    assign v_en = h_wrap & pix_en;

    vga_sync_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_ACT(SYNC_ACT)
    ) u_h (
        .clk(clk), .rst(rst), .en(pix_en),
        .pos(vga_x), .sync(hsync), .active(h_active), .wrap(h_wrap)
    );

    vga_sync_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_ACT(SYNC_ACT)
    ) u_v (
        .clk(clk), .rst(rst), .en(v_en),
        .pos(vga_y), .sync(vsync), .active(v_active), .wrap(v_wrap)
    );

    assign de = h_active & v_active;

    // Grey is computed for the position being entered so it moves with x/y.
    always_comb begin
        enter_frame = h_wrap & v_wrap;
        x_nxt       = h_wrap ? '0 : vga_x + 1'b1;
        y_nxt       = !h_wrap ? vga_y : (v_wrap ? '0 : vga_y + 1'b1);
        mode_nxt    = enter_frame ? pattern_e'(pattern_sel) : mode;
        bar_cnt_nxt = bar_cnt + 1'b1;
        bar_k_nxt   = bar_k;
        if (h_wrap) begin
            bar_cnt_nxt = '0;
            bar_k_nxt   = '0;
        end else if (bar_cnt == BAR_LAST) begin
            bar_cnt_nxt = '0;
            bar_k_nxt   = bar_k + 1'b1;
        end
        de_nxt   = (x_nxt < HA) && (y_nxt < VA);
        grey_nxt = 8'h00;
        if (de_nxt) begin
            case (mode_nxt)
                PAT_PASS:  grey_nxt = grey_in;
                PAT_RAMP:  grey_nxt = x_nxt[7:0];
                PAT_BARS:  grey_nxt = {bar_k_nxt, 5'b0};
                PAT_CHECK: grey_nxt = (x_nxt[5] ^ y_nxt[5]) ? 8'hFF : 8'h00;
                default:   grey_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= PAT_PASS;
            bar_cnt     <= '0;
            bar_k       <= '0;
            grey_out    <= 8'h00;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en & h_wrap;
            frame_start <= pix_en & enter_frame;
            if (pix_en) begin
                mode     <= mode_nxt;
                bar_cnt  <= bar_cnt_nxt;
                bar_k    <= bar_k_nxt;
                grey_out <= grey_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_raster_gen.sv
// Bench for vga_raster_gen on a shrunken raster (288x12 total) so full
// frames fit; outputs are compared every cycle against an arithmetic model.
module tb_vga_raster_gen;

    localparam int HA = 272, HF = 4, HS = 8, HB = 4;
    localparam int VA = 8,   VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [7:0]  grey_in = 8'd0;
    logic [10:0] vga_x, vga_y;
    logic        hsync, vsync, de, line_start, frame_start;
    logic [7:0]  grey_out;

    vga_raster_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .pattern_sel(pattern_sel),
        .grey_in(grey_in), .vga_x(vga_x), .vga_y(vga_y), .hsync(hsync),
        .vsync(vsync), .de(de), .line_start(line_start),
        .frame_start(frame_start), .grey_out(grey_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Reference state: position, latched mode and the output values.
    int mx, my, mmode, mgrey;
    bit mde, mls, mfs;

    function automatic int ref_grey(int x, int y, int mode, logic [7:0] gin);
        if (!(x < HA && y < VA)) return 0;
        case (mode)
            0:       return int'(gin);
            1:       return x % 256;
            2:       return (x / (HA / 8)) * 32;
            default: return (((x / 32) % 2) != ((y / 32) % 2)) ? 255 : 0;
        endcase
    endfunction

    function automatic logic [34:0] pk(int x, int y, bit hs, bit vs, bit d,
                                       bit ls, bit fs, int g);
        return {11'(x), 11'(y), hs, vs, d, ls, fs, 8'(g)};
    endfunction

    function automatic logic [34:0] ref_pk();
        bit hs, vs;
        hs = !(mx >= HA + HF && mx < HA + HF + HS);
        vs = !(my >= VA + VF && my < VA + VF + VS);
        return pk(mx, my, hs, vs, mde, mls, mfs, mgrey);
    endfunction

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b grey=%0d, want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b grey=%0d",
                     name, act[34:24], act[23:13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[34:24], exp[23:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [34:0] dut_pk();
        return {vga_x, vga_y, hsync, vsync, de, line_start, frame_start, grey_out};
    endfunction

    task automatic model(input bit pe, input bit r, input logic [1:0] sel, input logic [7:0] gin);
        if (r) begin
            mx = HT - 1; my = VT - 1; mmode = 0; mde = 0; mls = 0; mfs = 0; mgrey = 0;
        end else begin
            mls = 0; mfs = 0;
            if (pe) begin
                mx++;
                if (mx == HT) begin
                    mx = 0; my++;
                    if (my == VT) my = 0;
                end
                mls = (mx == 0);
                mfs = mls && (my == 0);
                if (mfs) mmode = int'(sel);
                mde = (mx < HA) && (my < VA);
                mgrey = ref_grey(mx, my, mmode, gin);
            end
        end
    endtask

    // Drive one clock of inputs, advance the model, sample 1 ns after the edge.
    task automatic apply(input bit pe, input bit r, input logic [1:0] sel, input logic [7:0] gin);
        @(negedge clk);
        pix_en = pe; rst = r; pattern_sel = sel; grey_in = gin;
        @(posedge clk);
        model(pe, r, sel, gin);
        #1;
    endtask

    task automatic step(input bit pe, input bit r, input logic [1:0] sel, input logic [7:0] gin);
        apply(pe, r, sel, gin);
        chk("model", dut_pk(), ref_pk());
    endtask

    typedef struct {
        bit pe; bit r; logic [1:0] sel; logic [7:0] gin;
        int x; int y; bit hs; bit vs; bit d; bit ls; bit fs; int g;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int gap, fs_seen, hs_lo, vs_lo, de_cnt, guard;

        tbl[0] = '{0, 1, 2'd0, 8'h00, HT-1, VT-1, 1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 2'd0, 8'h5A, 0, 0, 1, 1, 1, 1, 1, 8'h5A};
        tbl[2] = '{0, 0, 2'd2, 8'h11, 0, 0, 1, 1, 1, 0, 0, 8'h5A};
        tbl[3] = '{1, 0, 2'd2, 8'h33, 1, 0, 1, 1, 1, 0, 0, 8'h33};
        tbl[4] = '{1, 1, 2'd2, 8'h44, HT-1, VT-1, 1, 1, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 2'd2, 8'h55, 0, 0, 1, 1, 1, 1, 1, 0};

        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].pe, tbl[i].r, tbl[i].sel, tbl[i].gin);
            chk($sformatf("vec%0d", i), dut_pk(),
                pk(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].d, tbl[i].ls, tbl[i].fs, tbl[i].g));
        end

        // Bars on line 0, continuous strobes, with explicit bar edges.
        for (int i = 1; i < HT; i++) begin
            step(1, 0, 2'd1, 8'($urandom));
            case (mx)
                33:  chk_int("bar_x33", int'(grey_out), 0);
                34:  chk_int("bar_x34", int'(grey_out), 32);
                238: chk_int("bar_x238", int'(grey_out), 224);
                271: chk_int("bar_x271", int'(grey_out), 224);
                272: chk_int("bar_x272", int'(grey_out), 0);
                default: ;
            endcase
        end

        // Full frame with a strobe every third clock.
        step(0, 1, 2'd0, 8'd0);
        gap = 0; fs_seen = 0; hs_lo = 0; vs_lo = 0; de_cnt = 0;
        for (int s = 1; s <= HT*VT + 1; s++) begin
            step(1, 0, 2'd3, 8'($urandom));
            gap++;
            if (frame_start) begin
                if (fs_seen > 0) chk_int("frame_period", gap, HT*VT);
                fs_seen++; gap = 0;
            end
            if (s <= HT*VT) begin
                hs_lo  += (hsync == 1'b0) ? 1 : 0;
                vs_lo  += (vsync == 1'b0) ? 1 : 0;
                de_cnt += de ? 1 : 0;
            end
            step(0, 0, 2'd3, 8'($urandom));
            step(0, 0, 2'd3, 8'($urandom));
        end
        chk_int("frame_pulses", fs_seen, 2);
        chk_int("hsync_low_strobes", hs_lo, HS*VT);
        chk_int("vsync_low_strobes", vs_lo, VS*HT);
        chk_int("de_strobes", de_cnt, HA*VA);

        // Ramp latched, select moves to checker mid-frame, then mid-frame reset.
        step(0, 1, 2'd1, 8'd0);
        for (int s = 0; s < 1 + 5*HT + 200; s++) step(1, 0, 2'd1, 8'($urandom));
        guard = 0;
        while (!(mx == 40 && my == 0 && guard > 10) && guard < 2*HT*VT) begin
            step(1, 0, 2'd3, 8'($urandom));
            guard++;
            if (mx == 260 && my == 7) chk_int("ramp_wrap", int'(grey_out), 4);
        end
        chk_int("checker_next_frame", int'(grey_out), 255);
        guard = 0;
        while (!(mx == 250 && my == 6) && guard < 2*HT*VT) begin
            step(1, 0, 2'd3, 8'($urandom));
            guard++;
        end
        chk_int("reach_250_6", guard < 2*HT*VT ? 1 : 0, 1);
        apply(1, 1, 2'd3, 8'hFF);
        chk("mid_reset", dut_pk(), pk(HT-1, VT-1, 1, 1, 0, 0, 0, 0));

        // Each mode for a frame-plus under random strobes.
        for (int m = 0; m < 4; m++)
            for (int c = 0; c < 4200; c++)
                step(($urandom % 8) != 0, 0, 2'(m), 8'($urandom));

        // Random select churn with rare resets.
        for (int c = 0; c < 8000; c++)
            step(($urandom % 4) != 0, ($urandom % 3000) == 0, 2'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
